// File: rtl/coherence_arbiter.sv
// Round-robin bus arbiter and snoop coherence controller for NCPUS private I/D cache pairs.
// Optional macro CC_C2C_EN: dirty snoop hits are serviced by one cache-to-cache write-back transaction.
module coherence_arbiter #(
  parameter int unsigned NCPUS  = 2,
  parameter int unsigned WORD_W = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NCPUS-1:0]        iREN,
  input  logic [NCPUS*WORD_W-1:0] iaddr,
  output logic [NCPUS-1:0]        iwait,
  output logic [NCPUS*WORD_W-1:0] iload,
  input  logic [NCPUS-1:0]        dREN,
  input  logic [NCPUS-1:0]        dWEN,
  input  logic [NCPUS*WORD_W-1:0] daddr,
  input  logic [NCPUS*WORD_W-1:0] dstore,
  output logic [NCPUS-1:0]        dwait,
  output logic [NCPUS*WORD_W-1:0] dload,
  input  logic [NCPUS-1:0]        cctrans,
  input  logic [NCPUS-1:0]        ccwrite,
  output logic [NCPUS-1:0]        ccwait,
  output logic [NCPUS-1:0]        ccinv,
  output logic [NCPUS*WORD_W-1:0] ccsnoopaddr,
  output logic                    ramREN,
  output logic                    ramWEN,
  output logic [WORD_W-1:0]       ramaddr,
  output logic [WORD_W-1:0]       ramstore,
  input  logic [WORD_W-1:0]       ramload,
  input  logic                    ram_wait
);

  localparam int unsigned CW = (NCPUS > 1) ? $clog2(NCPUS) : 1;
  typedef logic [CW-1:0] idx_t;

  typedef enum logic [2:0] {
    IDLE, GRANT, SNOOP, SNPRESP, MEMRD, MEMWR
`ifdef CC_C2C_EN
    , C2C
`endif
  } state_t;

  state_t                    state_q;
  idx_t                      rr_q, req_q, snp_q;
  logic                      dside_q;
  logic [NCPUS-1:0]          iwait_q, dwait_q, ccwait_q, ccinv_q;
  logic [NCPUS*WORD_W-1:0]   iload_q, dload_q, ccsnoopaddr_q;
  logic                      ramREN_q, ramWEN_q;
  logic [WORD_W-1:0]         ramaddr_q, ramstore_q;
`ifndef CC_C2C_EN
  logic                      rdpend_q;
`endif

  idx_t wen_idx, ren_idx, ien_idx, snp_idx, rr_next;
  logic snp_hit;
  logic unused_cctrans;

  assign unused_cctrans = ^cctrans;

  // First set bit at or above start, wrapping; scanned top-down so the nearest one wins.
  function automatic idx_t rr_pick(input logic [NCPUS-1:0] req, input idx_t start);
    int unsigned pos;
    rr_pick = start;
    for (int unsigned k = NCPUS; k > 0; k--) begin
      pos = (32'(start) + k - 1) % NCPUS;
      if (req[pos]) rr_pick = idx_t'(pos);
    end
  endfunction

  assign wen_idx = rr_pick(dWEN, rr_q);
  assign ren_idx = rr_pick(dREN, rr_q);
  assign ien_idx = rr_pick(iREN, rr_q);
  assign rr_next = (req_q == idx_t'(NCPUS - 1)) ? '0 : req_q + 1'b1;

  always_comb begin
    snp_hit = 1'b0;
    snp_idx = '0;
    for (int unsigned j = NCPUS; j > 0; j--) begin
      if (ccwrite[j-1] && (idx_t'(j - 1) != req_q)) begin
        snp_hit = 1'b1;
        snp_idx = idx_t'(j - 1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= IDLE;
      rr_q          <= '0;
      req_q         <= '0;
      snp_q         <= '0;
      dside_q       <= 1'b0;
      iwait_q       <= '1;
      dwait_q       <= '1;
      iload_q       <= '0;
      dload_q       <= '0;
      ccwait_q      <= '0;
      ccinv_q       <= '0;
      ccsnoopaddr_q <= '0;
      ramREN_q      <= 1'b0;
      ramWEN_q      <= 1'b0;
      ramaddr_q     <= '0;
      ramstore_q    <= '0;
`ifndef CC_C2C_EN
      rdpend_q      <= 1'b0;
`endif
    end else begin
      iwait_q <= '1;
      dwait_q <= '1;
      case (state_q)
        IDLE: if (|{iREN, dREN, dWEN}) state_q <= GRANT;
        GRANT: begin
          if (|dWEN) begin
            req_q      <= wen_idx;
            dside_q    <= 1'b1;
            ramaddr_q  <= daddr[wen_idx*WORD_W +: WORD_W];
            ramstore_q <= dstore[wen_idx*WORD_W +: WORD_W];
            ramWEN_q   <= 1'b1;
            state_q    <= MEMWR;
          end else if (|dREN) begin
            req_q     <= ren_idx;
            dside_q   <= 1'b1;
            ramaddr_q <= daddr[ren_idx*WORD_W +: WORD_W];
            if (NCPUS == 1) begin
              ramREN_q <= 1'b1;
              state_q  <= MEMRD;
            end else begin
              for (int unsigned j = 0; j < NCPUS; j++) begin
                if (idx_t'(j) != ren_idx) begin
                  ccwait_q[j] <= 1'b1;
                  ccinv_q[j]  <= ccwrite[ren_idx];
                  ccsnoopaddr_q[j*WORD_W +: WORD_W] <= daddr[ren_idx*WORD_W +: WORD_W];
                end
              end
              state_q <= SNOOP;
            end
          end else if (|iREN) begin
            req_q     <= ien_idx;
            dside_q   <= 1'b0;
            ramaddr_q <= iaddr[ien_idx*WORD_W +: WORD_W];
            ramREN_q  <= 1'b1;
            state_q   <= MEMRD;
          end else begin
            state_q <= IDLE;
          end
        end
        SNOOP: state_q <= SNPRESP;
        SNPRESP: begin
          ccwait_q <= '0;
          ccinv_q  <= '0;
          if (snp_hit) begin
            snp_q      <= snp_idx;
            ramstore_q <= dstore[snp_idx*WORD_W +: WORD_W];
            ramWEN_q   <= 1'b1;
`ifdef CC_C2C_EN
            state_q    <= C2C;
`else
            rdpend_q   <= 1'b1;
            state_q    <= MEMWR;
`endif
          end else begin
            ramREN_q <= 1'b1;
            state_q  <= MEMRD;
          end
        end
        MEMRD: if (!ram_wait) begin
          ramREN_q <= 1'b0;
          if (dside_q) begin
            dwait_q[req_q] <= 1'b0;
            dload_q[req_q*WORD_W +: WORD_W] <= ramload;
          end else begin
            iwait_q[req_q] <= 1'b0;
            iload_q[req_q*WORD_W +: WORD_W] <= ramload;
          end
          rr_q    <= rr_next;
          state_q <= IDLE;
        end
        MEMWR: if (!ram_wait) begin
          ramWEN_q <= 1'b0;
`ifndef CC_C2C_EN
          // Snooper write-back finished: release it and read the fresh line for the requester.
          if (rdpend_q) begin
            rdpend_q       <= 1'b0;
            dwait_q[snp_q] <= 1'b0;
            ramREN_q       <= 1'b1;
            state_q        <= MEMRD;
          end else
`endif
          begin
            dwait_q[req_q] <= 1'b0;
            rr_q           <= rr_next;
            state_q        <= IDLE;
          end
        end
`ifdef CC_C2C_EN
        C2C: if (!ram_wait) begin
          ramWEN_q       <= 1'b0;
          dload_q[req_q*WORD_W +: WORD_W] <= ramstore_q;
          dwait_q[req_q] <= 1'b0;
          dwait_q[snp_q] <= 1'b0;
          rr_q           <= rr_next;
          state_q        <= IDLE;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign iwait       = iwait_q;
  assign dwait       = dwait_q;
  assign iload       = iload_q;
  assign dload       = dload_q;
  assign ccwait      = ccwait_q;
  assign ccinv       = ccinv_q;
  assign ccsnoopaddr = ccsnoopaddr_q;
  assign ramREN      = ramREN_q;
  assign ramWEN      = ramWEN_q;
  assign ramaddr     = ramaddr_q;
  assign ramstore    = ramstore_q;

endmodule
